// File: rtl/dsa_step_controller_if.sv
// -----------------------------------------------------------------------------
// dsa_step_controller_if
// Debug command channel between the JTAG command decoder and the DSA step
// controller. A command is taken on any clock where valid && ready.
//   valid  : command strobe (master -> slave)
//   ready  : controller can accept a command (slave -> master)
//   op     : 0 NOP, 1 RUN, 2 PAUSE, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CNT, 7 NOP
//   arg    : STEP -> [15:0] step count; SET_BP -> {bp_y[31:16], bp_x[15:0]}
// -----------------------------------------------------------------------------
interface dsa_step_controller_if;
    logic        valid;
    logic        ready;
    logic [2:0]  op;
    logic [31:0] arg;

    modport master (output valid, output op, output arg, input ready);
    modport slave  (input valid, input op, input arg, output ready);
endinterface

// File: rtl/dsa_step_controller.sv
// -----------------------------------------------------------------------------
// dsa_step_controller
// Run / pause / single-step sequencer for the bilinear DSA datapath. The
// datapath FSM may only move while o_dsa_advance is high. In stepping mode each
// step releases the datapath for exactly one cycle (ISSUE), then waits (WAIT)
// for the datapath state to change or for a timeout before acknowledging.
// A coordinate breakpoint pauses free running at a chosen output pixel.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_if              debug command channel (slave side)
//   i_fsm_state         live datapath FSM state
//   i_current_x/_y      live output-pixel coordinates
//   o_dsa_advance       datapath may take a transition this cycle
//   o_capture_enable    stepping active (controller not in RUN)
//   o_step_ack          one-cycle pulse per completed step
//   o_ctrl_state        0 RUN, 1 PAUSED, 2 ISSUE, 3 WAIT
//   o_steps_remaining   steps left in the current burst
//   o_step_counter      total completed steps (wrapping)
//   o_bp_hit            sticky: breakpoint caused a pause
//   o_step_timeout      sticky: a step was acknowledged by timeout
// -----------------------------------------------------------------------------
module dsa_step_controller #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    dsa_step_controller_if.slave cmd_if,
    input  logic [3:0]           i_fsm_state,
    input  logic [15:0]          i_current_x,
    input  logic [15:0]          i_current_y,
    output logic                 o_dsa_advance,
    output logic                 o_capture_enable,
    output logic                 o_step_ack,
    output logic [1:0]           o_ctrl_state,
    output logic [15:0]          o_steps_remaining,
    output logic [CNT_WIDTH-1:0] o_step_counter,
    output logic                 o_bp_hit,
    output logic                 o_step_timeout
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_RUN     = 3'd1;
    localparam logic [2:0] OP_PAUSE   = 3'd2;
    localparam logic [2:0] OP_STEP    = 3'd3;
    localparam logic [2:0] OP_SET_BP  = 3'd4;
    localparam logic [2:0] OP_CLR_BP  = 3'd5;
    localparam logic [2:0] OP_CLR_CNT = 3'd6;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t               r_state, w_state_next;
    logic                 r_cmd_ready, r_capture, r_adv_base, r_step_ack;
    logic [15:0]          r_steps, w_steps_next;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                 r_bp_hit, w_bp_hit_next;
    logic                 r_tmo_flag, w_tmo_flag_next;
    logic                 r_bp_en, w_bp_en_next;
    logic                 r_bp_armed, w_bp_armed_next;
    logic [15:0]          r_bp_x, w_bp_x_next, r_bp_y, w_bp_y_next;
    logic [TW-1:0]        r_tmo_cnt, w_tmo_cnt_next;
    logic [3:0]           r_snap, w_snap_next;
    logic                 w_ack_next;
    logic                 w_accept, w_bp_match, w_bp_fire, w_changed, w_expired;
    logic [15:0]          w_steps_dec;

    assign w_accept    = cmd_if.valid && r_cmd_ready;
    assign w_bp_match  = r_bp_en && (i_current_x == r_bp_x) && (i_current_y == r_bp_y);
    assign w_bp_fire   = w_bp_match && r_bp_armed && (r_state == ST_RUN);
    assign w_changed   = (i_fsm_state != r_snap);
    assign w_expired   = (r_tmo_cnt == TMO_LAST);
    assign w_steps_dec = r_steps - 16'd1;

    // Next-state, counters, breakpoint and sticky-flag logic.
    always_comb begin
        w_state_next    = r_state;
        w_steps_next    = r_steps;
        w_cnt_next      = r_cnt;
        w_bp_hit_next   = r_bp_hit;
        w_tmo_flag_next = r_tmo_flag;
        w_bp_en_next    = r_bp_en;
        w_bp_x_next     = r_bp_x;
        w_bp_y_next     = r_bp_y;
        w_tmo_cnt_next  = r_tmo_cnt;
        w_snap_next     = r_snap;
        w_ack_next      = 1'b0;

        case (r_state)
            ST_RUN: begin
                // An accepted command picks the next state; a breakpoint only
                // records a hit when the command does not resume running.
                if (w_accept && cmd_if.op == OP_RUN) begin
                    w_state_next = ST_RUN;
                end else if (w_accept && cmd_if.op == OP_PAUSE) begin
                    w_state_next = ST_PAUSED;
                end else if (w_accept && cmd_if.op == OP_STEP) begin
                    w_state_next = ST_ISSUE;
                end else if (w_bp_fire) begin
                    w_state_next = ST_PAUSED;
                end else begin
                    w_state_next = ST_RUN;
                end
                if (w_bp_fire && !(w_accept && cmd_if.op == OP_RUN)) begin
                    w_bp_hit_next = 1'b1;
                end else begin
                    w_bp_hit_next = r_bp_hit;
                end
            end
            ST_PAUSED: begin
                if (w_accept && cmd_if.op == OP_RUN) begin
                    w_state_next = ST_RUN;
                end else if (w_accept && cmd_if.op == OP_STEP) begin
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_PAUSED;
                end
            end
            ST_ISSUE: begin
                w_snap_next    = i_fsm_state;
                w_tmo_cnt_next = '0;
                w_state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_changed || w_expired) begin
                    w_ack_next      = 1'b1;
                    w_cnt_next      = r_cnt + CNT_WIDTH'(1);
                    w_steps_next    = w_steps_dec;
                    w_state_next    = (w_steps_dec != 16'd0) ? ST_ISSUE : ST_PAUSED;
                    w_tmo_flag_next = (!w_changed) ? 1'b1 : r_tmo_flag;
                end else begin
                    w_tmo_cnt_next  = r_tmo_cnt + TW'(1);
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // Commands are only accepted in RUN/PAUSED, so a step increment and
        // CLR_CNT cannot collide; if they did, the clear listed last wins.
        if (w_accept) begin
            case (cmd_if.op)
                OP_RUN: begin
                    w_bp_hit_next   = 1'b0;
                    w_tmo_flag_next = 1'b0;
                end
                OP_STEP: begin
                    w_steps_next = (cmd_if.arg[15:0] == 16'd0) ? 16'd1 : cmd_if.arg[15:0];
                end
                OP_SET_BP: begin
                    w_bp_x_next  = cmd_if.arg[15:0];
                    w_bp_y_next  = cmd_if.arg[31:16];
                    w_bp_en_next = 1'b1;
                end
                OP_CLR_BP: begin
                    w_bp_en_next  = 1'b0;
                    w_bp_hit_next = 1'b0;
                end
                OP_CLR_CNT: begin
                    w_cnt_next = '0;
                end
                default: begin
                    w_cnt_next = w_cnt_next;
                end
            endcase
        end else begin
            w_cnt_next = w_cnt_next;
        end

        // Arming requires having seen a non-matching pixel, so resuming at the
        // breakpoint pixel does not immediately re-trigger.
        if (w_bp_fire || (w_accept && (cmd_if.op == OP_SET_BP || cmd_if.op == OP_RUN ||
                                       cmd_if.op == OP_CLR_BP))) begin
            w_bp_armed_next = 1'b0;
        end else if (r_bp_en && !w_bp_match) begin
            w_bp_armed_next = 1'b1;
        end else begin
            w_bp_armed_next = r_bp_armed;
        end
    end

    // State, datapath bookkeeping and registered output decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cmd_ready <= 1'b1;
            r_capture   <= 1'b0;
            r_adv_base  <= 1'b1;
            r_step_ack  <= 1'b0;
            r_steps     <= 16'd0;
            r_cnt       <= '0;
            r_bp_hit    <= 1'b0;
            r_tmo_flag  <= 1'b0;
            r_bp_en     <= 1'b0;
            r_bp_armed  <= 1'b0;
            r_bp_x      <= 16'd0;
            r_bp_y      <= 16'd0;
            r_tmo_cnt   <= '0;
            r_snap      <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_ready <= (w_state_next == ST_RUN) || (w_state_next == ST_PAUSED);
            r_capture   <= (w_state_next != ST_RUN);
            r_adv_base  <= (w_state_next == ST_RUN) || (w_state_next == ST_ISSUE);
            r_step_ack  <= w_ack_next;
            r_steps     <= w_steps_next;
            r_cnt       <= w_cnt_next;
            r_bp_hit    <= w_bp_hit_next;
            r_tmo_flag  <= w_tmo_flag_next;
            r_bp_en     <= w_bp_en_next;
            r_bp_armed  <= w_bp_armed_next;
            r_bp_x      <= w_bp_x_next;
            r_bp_y      <= w_bp_y_next;
            r_tmo_cnt   <= w_tmo_cnt_next;
            r_snap      <= w_snap_next;
        end
    end

    // The breakpoint must stop the datapath in the very cycle the pixel appears.
    assign o_dsa_advance     = r_adv_base && !w_bp_fire;
    assign cmd_if.ready      = r_cmd_ready;
    assign o_capture_enable  = r_capture;
    assign o_step_ack        = r_step_ack;
    assign o_ctrl_state      = r_state;
    assign o_steps_remaining = r_steps;
    assign o_step_counter    = r_cnt;
    assign o_bp_hit          = r_bp_hit;
    assign o_step_timeout    = r_tmo_flag;
endmodule
